// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector, samples dut_out, checks it against EXP_TABLE.
// Latency: done rises HOLD_CYCLES*2**N_IN + 1 clocks after the start edge.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while a sweep runs.
//
// Ports: clk, rst (async active-high), start; dut_in/dut_out connect the block under test;
// busy/done/pass, err_count, fail_seen, first_fail_vec report the sweep result.
// Optional macro SWEEP_SIGNATURE_EN adds a 16-bit CRC-16-CCITT MISR output 'signature'.
module truth_table_sweeper #(
  parameter int N_IN        = 2,
  parameter int N_OUT       = 1,
  parameter int HOLD_CYCLES = 10,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_seen,
  output logic [N_IN-1:0]   first_fail_vec
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]       signature
`endif
);

  localparam int              HW        = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hold;
  logic [N_OUT-1:0] exp_out;
  logic            sample;
  logic            mismatch;

  always_comb begin
    exp_out = EXP_TABLE[int'(dut_in)*N_OUT +: N_OUT];
    sample  = (state == S_DRIVE) && (hold == HOLD_LAST);
    // Case inequality: an X/Z response counts as a mismatch in simulation;
    // in hardware it reduces to a plain bitwise compare.
    mismatch = (dut_out !== exp_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      hold           <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
`ifdef SWEEP_SIGNATURE_EN
      signature      <= 16'hFFFF;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_DRIVE;
            hold           <= '0;
            dut_in         <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
`ifdef SWEEP_SIGNATURE_EN
            signature      <= 16'hFFFF;
`endif
          end else if (state == S_DONE) begin
            // Result flags register one clock after the final sample so
            // pass sees the fully updated error count.
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0);
          end
        end

        S_DRIVE: begin
          if (sample) begin
            hold <= '0;
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (!fail_seen) begin
                fail_seen      <= 1'b1;
                first_fail_vec <= dut_in;
              end
            end
`ifdef SWEEP_SIGNATURE_EN
            signature <= {signature[14:0], 1'b0}
                       ^ ({16{signature[15]}} & 16'h1021)
                       ^ {{(16-N_OUT){1'b0}}, dut_out};
`endif
            // The last vector stays on dut_in once the sweep completes.
            if (dut_in == VEC_LAST) state  <= S_DONE;
            else                    dut_in <= dut_in + 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default 2-input instance driven by a programmable truth-table DUT,
// plus a 3-input/2-output instance against a stuck-0 DUT.
// Expected results come from a table-difference model computed in the bench.
module tb_truth_table_sweeper;

  localparam int          HOLD  = 10;
  localparam logic [3:0]  AND_T = 4'b1000;
  localparam logic [15:0] TBL3  = 16'h40C8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  dut_in;
  logic        dut_out;
  logic        busy, done, pass, fail_seen;
  logic [2:0]  err_count;
  logic [1:0]  first_fail_vec;
  logic [3:0]  fn;

  logic        start3;
  logic [2:0]  dut_in3;
  logic [1:0]  dut_out3;
  logic        busy3, done3, pass3, fail3;
  logic [3:0]  err3;
  logic [2:0]  ffv3;

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] signature, sig3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign dut_out  = fn[dut_in];
  assign dut_out3 = 2'b00;

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_seen(fail_seen),
    .first_fail_vec(first_fail_vec)
`ifdef SWEEP_SIGNATURE_EN
    , .signature(signature)
`endif
  );

  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD_CYCLES(2), .EXP_TABLE(TBL3)) u_wide (
    .clk(clk), .rst(rst), .start(start3),
    .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_seen(fail3),
    .first_fail_vec(ffv3)
`ifdef SWEEP_SIGNATURE_EN
    , .signature(sig3)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a vector fails when the DUT function differs from AND there.
  function automatic int model_errs(input logic [3:0] f);
    int n = 0;
    for (int v = 0; v < 4; v++) if (f[v] != AND_T[v]) n++;
    return n;
  endfunction

  function automatic int model_first(input logic [3:0] f);
    for (int v = 0; v < 4; v++) if (f[v] != AND_T[v]) return v;
    return 0;
  endfunction

  function automatic logic [15:0] crc_model(input logic [3:0] f);
    logic [15:0] s = 16'hFFFF;
    for (int v = 0; v < 4; v++)
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, f[v]};
    return s;
  endfunction

  // Pulses start, then follows the sweep; ign1/ign2 are cycle indices at which
  // a stray start pulse is injected. lat = clocks from the start edge to done.
  task automatic sweep(input int ign1, input int ign2,
                       output int lat, output int bad_in, output int bad_busy);
    logic [1:0] exp_v;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = -1; bad_in = 0; bad_busy = 0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin lat = k; break; end
      exp_v = 2'((k / HOLD > 3) ? 3 : k / HOLD);
      if (dut_in !== exp_v) bad_in++;
      if (busy !== 1'b1) bad_busy++;
      start = (k == ign1 || k == ign2);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] f, input int lat);
    int  e_err   = model_errs(f);
    int  e_first = model_first(f);
    checks++; if (lat !== 41) begin errors++; $display("FAIL %s latency: got %0d want 41", tag, lat); end
    checks++; if (int'(err_count) !== e_err) begin errors++; $display("FAIL %s err_count: got %0d want %0d", tag, err_count, e_err); end
    checks++; if (pass !== (e_err == 0)) begin errors++; $display("FAIL %s pass: got %0b want %0b", tag, pass, e_err == 0); end
    checks++; if (fail_seen !== (e_err != 0)) begin errors++; $display("FAIL %s fail_seen: got %0b want %0b", tag, fail_seen, e_err != 0); end
    if (e_err != 0) begin
      checks++; if (int'(first_fail_vec) !== e_first) begin errors++; $display("FAIL %s first_fail_vec: got %0d want %0d", tag, first_fail_vec, e_first); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after done: got %0b want 0", tag, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; fn = AND_T;
    repeat (2) @(negedge clk);
    checks++;
    if ({dut_in, busy, done, pass, err_count, fail_seen, first_fail_vec} !== 11'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {dut_in, busy, done, pass, err_count, fail_seen, first_fail_vec});
    end
    checks++;
    if ({dut_in3, busy3, done3, pass3, err3, fail3, ffv3} !== 16'b0) begin
      errors++; $display("FAIL reset_wide_outputs: got %b want 0", {dut_in3, busy3, done3, pass3, err3, fail3, ffv3});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_and_pass;
    int lat, bi, bb;
    fn = AND_T;
    sweep(15, 30, lat, bi, bb);
    check_result("and", fn, lat);
    checks++; if (bi !== 0) begin errors++; $display("FAIL and dut_in_sequence: got %0d bad cycles want 0", bi); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL and busy_during_sweep: got %0d bad cycles want 0", bb); end
    repeat (5) @(negedge clk);
    checks++; if ({done, pass, dut_in} !== 4'b1111) begin errors++; $display("FAIL and frozen_in_done: got %b want 1111", {done, pass, dut_in}); end
  endtask

  task automatic test_or_fail;
    int lat, bi, bb;
    fn = 4'b1110;
    sweep(-1, -1, lat, bi, bb);
    check_result("or", fn, lat);
  endtask

  task automatic test_random_functions;
    int lat, bi, bb;
    for (int i = 0; i < 4; i++) begin
      fn = 4'($urandom);
      sweep($urandom_range(1, 38), $urandom_range(1, 38), lat, bi, bb);
      check_result($sformatf("rand%0d_fn%b", i, fn), fn, lat);
      checks++; if (bi !== 0) begin errors++; $display("FAIL rand%0d dut_in_sequence: got %0d bad cycles want 0", i, bi); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, bi, bb;
    fn = 4'b0111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat ($urandom_range(12, 35)) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dut_in, busy, done, pass, err_count, fail_seen, first_fail_vec} !== 11'b0) begin
      errors++; $display("FAIL reset_mid_async: got %b want 0", {dut_in, busy, done, pass, err_count, fail_seen, first_fail_vec});
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_mid_idle: got %b want 00", {busy, done}); end
    fn = AND_T;
    sweep(-1, -1, lat, bi, bb);
    check_result("after_reset", fn, lat);
  endtask

  task automatic test_wide;
    int lat = -1;
    int e_err = 0;
    int e_first = -1;
    logic [15:0] t = TBL3;
    for (int v = 0; v < 8; v++)
      if (t[v*2 +: 2] != 2'b00) begin e_err++; if (e_first < 0) e_first = v; end
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (done3) begin lat = k; break; end
    end
    checks++; if (lat !== 17) begin errors++; $display("FAIL wide latency: got %0d want 17", lat); end
    checks++; if (int'(err3) !== e_err) begin errors++; $display("FAIL wide err_count: got %0d want %0d", err3, e_err); end
    checks++; if (int'(ffv3) !== e_first) begin errors++; $display("FAIL wide first_fail_vec: got %0d want %0d", ffv3, e_first); end
    checks++; if ({pass3, fail3, dut_in3} !== 5'b01111) begin errors++; $display("FAIL wide flags: got %b want 01111", {pass3, fail3, dut_in3}); end
  endtask

`ifdef SWEEP_SIGNATURE_EN
  task automatic test_signature;
    int lat, bi, bb;
    logic [15:0] want = crc_model(AND_T);
    fn = AND_T;
    for (int r = 0; r < 2; r++) begin
      sweep(-1, -1, lat, bi, bb);
      checks++; if (signature !== want) begin errors++; $display("FAIL signature run%0d: got %h want %h", r, signature, want); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_and_pass;
    test_or_fail;
    test_random_functions;
    test_reset_mid;
    test_wide;
`ifdef SWEEP_SIGNATURE_EN
    test_signature;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
